// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_nrw register bank and its clear sequencer.
package regfile_pkg;

    typedef enum logic {
        IDLE,
        SWEEP
    } clr_state_t;

    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: on a CLR pulse, walks a pointer over every register for DEPTH cycles,
// asserting clr_en with the address to zero each cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        busy_o     = 1'b0;
        clr_en_o   = 1'b0;
        clr_addr_o = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                busy_o   = 1'b1;
                clr_en_o = 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/regfile_nrw.sv
// DEPTH x WIDTH register file: one write port, two registered read ports with write bypass,
// and a hardware clear sweep. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_nrw
    import regfile_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [WIDTH-1:0]  WR_DATA,
    output logic              WR_READY,
    input  logic [ADDR_W-1:0] RD_ADDR_A,
    output logic [WIDTH-1:0]  RD_DATA_A,
    input  logic [ADDR_W-1:0] RD_ADDR_B,
    output logic [WIDTH-1:0]  RD_DATA_B,
    input  logic              CLR,
    output logic              BUSY
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic                         busy;
    logic                         clr_en;
    logic [ADDR_W-1:0]            clr_addr;
    logic                         wr_fire;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_rd;
    logic [WIDTH-1:0]             rd_a_d, rd_a_q;
    logic [WIDTH-1:0]             rd_b_d, rd_b_q;

    regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk_i      (CLK),
        .rst_ni     (RESET),
        .clr_i      (CLR),
        .busy_o     (busy),
        .clr_en_o   (clr_en),
        .clr_addr_o (clr_addr)
    );

    assign BUSY     = busy;
    assign WR_READY = !busy;
    assign wr_fire  = WR_EN && !busy && addr_in_range(32'(WR_ADDR), 32'(DEPTH));

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG && i == 0) begin : g_zero
            assign mem_rd[i] = '0;
        end else begin : g_reg
            logic [WIDTH-1:0] entry_q;
            // NOTE: the register array is reset explicitly because reset must zero every entry.
            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    entry_q <= '0;
                end else if (clr_en && clr_addr == ADDR_W'(i)) begin
                    entry_q <= '0;
                end else if (wr_fire && WR_ADDR == ADDR_W'(i)) begin
                    entry_q <= WR_DATA;
                end
            end
            assign mem_rd[i] = entry_q;
        end
    end

    // Value an entry will hold after this edge; writes and sweeps never coincide.
    function automatic logic [WIDTH-1:0] next_rd(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] val;
        val = '0;
        if (!addr_in_range(32'(addr), 32'(DEPTH)) || (ZERO_REG && addr == '0)) begin
            val = '0;
        end else if (clr_en && clr_addr == addr) begin
            val = '0;
        end else if (wr_fire && WR_ADDR == addr) begin
            val = WR_DATA;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr == ADDR_W'(i)) val = mem_rd[i];
            end
        end
        return val;
    endfunction

    always_comb begin
        rd_a_d = next_rd(RD_ADDR_A);
        rd_b_d = next_rd(RD_ADDR_B);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
        end
    end

    assign RD_DATA_A = rd_a_q;
    assign RD_DATA_B = rd_b_q;

endmodule

// File: tb/tb_regfile_nrw.sv
// Self-checking bench for regfile_nrw: behavioural model compared every cycle plus directed
// literal expectations; a second DEPTH=6 instance covers non-power-of-2 and register 0.
module tb_regfile_nrw;

    localparam int DEPTH = 8;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       we, clr;
    logic [2:0] wa, ra, rb;
    logic [7:0] wd;
    logic [7:0] rd_a, rd_b;
    logic       wr_ready, busy;

    logic       we6, clr6;
    logic [2:0] wa6, ra6, rb6;
    logic [7:0] wd6;
    logic [7:0] rd_a6, rd_b6;
    logic       wr_ready6, busy6;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int busy_cnt;

    regfile_nrw #(.WIDTH(8), .DEPTH(8)) dut (
        .CLK(clk), .RESET(rst_n), .WR_EN(we), .WR_ADDR(wa), .WR_DATA(wd), .WR_READY(wr_ready),
        .RD_ADDR_A(ra), .RD_DATA_A(rd_a), .RD_ADDR_B(rb), .RD_DATA_B(rd_b),
        .CLR(clr), .BUSY(busy)
    );

    regfile_nrw #(.WIDTH(8), .DEPTH(6)) dut6 (
        .CLK(clk), .RESET(rst_n), .WR_EN(we6), .WR_ADDR(wa6), .WR_DATA(wd6), .WR_READY(wr_ready6),
        .RD_ADDR_A(ra6), .RD_DATA_A(rd_a6), .RD_ADDR_B(rb6), .RD_DATA_B(rd_b6),
        .CLR(clr6), .BUSY(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: contents array, registered read values and remaining sweep cycles.
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_rd_a, m_rd_b;
    int         m_busy_left = 0;

    function automatic logic [7:0] m_next(input int a);
        if (a >= DEPTH) return 8'h00;
        if (ZR && a == 0) return 8'h00;
        if (m_busy_left > 0 && a == DEPTH - m_busy_left) return 8'h00;
        if (we && m_busy_left == 0 && int'(wa) == a) return wd;
        return m_mem[a];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= 8'h00;
            m_rd_a      <= 8'h00;
            m_rd_b      <= 8'h00;
            m_busy_left <= 0;
        end else begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= m_next(i);
            m_rd_a <= m_next(int'(ra));
            m_rd_b <= m_next(int'(rb));
            if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
            else if (clr)        m_busy_left <= DEPTH;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd_a", 32'(rd_a), 32'(m_rd_a));
            check("model_rd_b", 32'(rd_b), 32'(m_rd_b));
            check("model_busy", 32'(busy), 32'(m_busy_left > 0));
            check("model_wr_ready", 32'(wr_ready), 32'(m_busy_left == 0));
        end
    end

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            n++;
            clr = (k == 3);
            tick();
        end
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; clr = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        we6 = 1'b0; clr6 = 1'b0; wa6 = '0; wd6 = '0; ra6 = '0; rb6 = '0;

        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1; ra = 3'd3; rb = 3'd7;
        tick();
        check("reset_rd_a", 32'(rd_a), 32'h00);
        check("reset_rd_b", 32'(rd_b), 32'h00);
        check("reset_wr_ready", 32'(wr_ready), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);

        we = 1'b1; wa = 3'd5; wd = 8'h11;
        tick();
        wa = 3'd2; wd = 8'hA5;
        tick();
        we = 1'b0; ra = 3'd2;
        tick();
        check("latency_rd_a", 32'(rd_a), 32'hA5);

        we = 1'b1; wa = 3'd5; wd = 8'h3C; ra = 3'd5; rb = 3'd5;
        tick();
        we = 1'b0;
        check("bypass_rd_a", 32'(rd_a), 32'h3C);
        check("bypass_rd_b", 32'(rd_b), 32'h3C);
        tick();
        check("after_bypass_rd_a", 32'(rd_a), 32'h3C);

        for (int i = 0; i < DEPTH; i++) begin
            we = 1'b1; wa = 3'(i); wd = 8'hFF;
            tick();
        end
        we = 1'b0; ra = 3'd1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        we = 1'b1; wa = 3'd1; wd = 8'h77;
        count_busy(busy_cnt);
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        check("sweep_done_wr_ready", 32'(wr_ready), 32'h1);
        check("held_write_not_early", 32'(rd_a), 32'h00);
        tick();
        we = 1'b0;
        check("held_write_bypass", 32'(rd_a), 32'h77);
        for (int i = 0; i < DEPTH; i++) begin
            ra = 3'(i); rb = 3'((i + 1) % DEPTH);
            tick();
            check("post_sweep_rd_a", 32'(rd_a), (i == 1) ? 32'h77 : 32'h00);
        end

        we = 1'b1; wa = 3'd4; wd = 8'h44;
        tick();
        we = 1'b0; ra = 3'd4; rb = 3'd1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midsweep_reset_busy", 32'(busy), 32'h0);
        check("midsweep_reset_rd_a", 32'(rd_a), 32'h00);
        tick();
        check("after_reset_addr4", 32'(rd_a), 32'h00);
        check("after_reset_addr1", 32'(rd_b), 32'h00);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_busy(busy_cnt);
        check("fresh_sweep_busy_cycles", 32'(busy_cnt), 32'd8);

        we6 = 1'b1; wa6 = 3'd6; wd6 = 8'h09;
        tick();
        wa6 = 3'd0; wd6 = 8'h55;
        tick();
        wa6 = 3'd5; wd6 = 8'h5A;
        tick();
        we6 = 1'b0; ra6 = 3'd6; rb6 = 3'd0;
        tick();
        check("d6_out_of_range_read", 32'(rd_a6), 32'h00);
        check("d6_addr0_read", 32'(rd_b6), ZR ? 32'h00 : 32'h55);
        ra6 = 3'd5; rb6 = 3'd7;
        tick();
        check("d6_last_entry", 32'(rd_a6), 32'h5A);
        check("d6_addr7_read", 32'(rd_b6), 32'h00);
        we6 = 1'b1; wa6 = 3'd0; wd6 = 8'h66; ra6 = 3'd0;
        tick();
        we6 = 1'b0;
        check("d6_addr0_bypass", 32'(rd_a6), ZR ? 32'h00 : 32'h66);
        check("d6_wr_ready", 32'(wr_ready6), 32'h1);
        check("d6_busy", 32'(busy6), 32'h0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_nrw.md
Name: regfile_nrw

Overview:
Parametrised successor to the 8x8 register bank. Provides DEPTH registers of WIDTH bits with one write port and two independent registered read ports (A, B). Adds write-to-read bypass and a hardware clear sequencer that sweeps all registers to zero on request. Sits between the instruction decoder and the ALU operand muxes.

Parameters:
WIDTH, 8, data width of each register
DEPTH, 8, number of registers (>=2, need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous active-low reset; sampled on the rising edge of CLK
WR_EN  input  1  write request
WR_ADDR  input  ADDR_W  write address
WR_DATA  input  WIDTH  write data
WR_READY  output  1  write accepted this cycle when WR_EN && WR_READY
RD_ADDR_A  input  ADDR_W  read port A address
RD_DATA_A  output  WIDTH  read port A data, 1-cycle latency
RD_ADDR_B  input  ADDR_W  read port B address
RD_DATA_B  output  WIDTH  read port B data, 1-cycle latency
CLR  input  1  single-cycle request to start the clear sweep
BUSY  output  1  clear sweep in progress

Behaviour:
- Reset (RESET==0 at an edge): all registers set to 0; RD_DATA_A/B=0; FSM returns to IDLE; sweep pointer=0; BUSY=0; WR_READY=1 from the next cycle. Reset overrides everything, including mid-sweep.
- WR_READY is combinational: WR_READY = !BUSY.
- Write: if WR_EN && WR_READY && WR_ADDR<DEPTH, then mem[WR_ADDR] <= WR_DATA. A write to an out-of-range address is dropped silently.
- Read: RD_DATA_x <= next value of mem[RD_ADDR_x], so the data shown one cycle later reflects that cycle's updates.
  - Bypass: an accepted write to the same address in the same cycle delivers WR_DATA.
  - A sweep clearing that address in the same cycle delivers 0.
  - An out-of-range address delivers 0.
  - Ports A and B are fully independent and may use the same address.
- Clear FSM states: IDLE, SWEEP.
  - IDLE: CLR=1 goes to SWEEP next cycle with ptr=0. A write accepted in that same cycle still completes; the sweep later zeroes it.
  - SWEEP: BUSY=1; each cycle mem[ptr] <= 0 and ptr increments. When ptr==DEPTH-1 the FSM returns to IDLE.
  - The sweep lasts exactly DEPTH cycles. BUSY rises the cycle after CLR is sampled and falls after the last clear.
  - CLR during SWEEP is ignored (no restart).
  - WR_EN during SWEEP is not accepted; the requester must hold WR_EN until WR_READY=1.
  - Reads during SWEEP return current contents: 0 for already-cleared addresses, old data for the rest.
- No X on outputs after the first reset edge.

Optional Feature:
Macro: REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Writes to address 0 are accepted (WR_READY unaffected) but discarded. Reads of address 0 return 0, with no bypass. Storage for entry 0 is not synthesised.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg contains:
  - typedef enum logic {IDLE, SWEEP} clr_state_t
  - function addr_in_range(addr, depth)
- Sub-module regfile_clear_seq holds the FSM and sweep pointer. Its outputs are BUSY, clr_en and clr_addr. The register array and read/bypass logic stay in the top module.

Test Plan:
- Reset then read: hold RESET=0 for 2 cycles, release, read A=3, B=7 -> RD_DATA_A=0x00, RD_DATA_B=0x00 one cycle later; WR_READY=1.
- Write/read latency: write 0xA5 to addr 2 at cycle t, read A=2 at t+1 -> RD_DATA_A=0xA5 at t+2.
- Bypass: write 0x3C to addr 5 while A=5 and B=5 in the same cycle -> both ports show 0x3C next cycle. Old data 0x11 must never appear.
- Clear sweep (DEPTH=8): fill all registers with 0xFF, pulse CLR.
  - BUSY is high for exactly 8 cycles.
  - WR_READY=0 throughout; a held WR_EN to addr 1 with 0x77 completes only on the first cycle after BUSY falls.
  - Afterwards all addresses except 1 read 0x00, and addr 1 reads 0x77.
- Reset mid-sweep: pulse CLR, assert RESET=0 at sweep cycle 3 -> next cycle BUSY=0 and all registers read 0. A CLR pulse 2 cycles later starts a fresh 8-cycle sweep.
- Non-power-of-2 depth and zero register: DEPTH=6.
  - Write 0x9 to addr 6 -> dropped; a read of addr 6 returns 0.
  - With REGFILE_ZERO_REG_EN defined, write 0x55 to addr 0 -> a read of addr 0 returns 0x00.
